pwm_led_driver: RTL and testbench
=================================

// Module: pwm_led_driver
//
// PURPOSE
//   Multi-channel PWM generator for GPO-driven LEDs and pins, replacing the 1-bit on/off gpo drive.
//   Per-channel duty written over a valid/ready port into shadow registers.
//   Shadow values are applied glitch-free at PWM period boundaries.
//   Sits between the core's GPO/MMIO write path and the pad or RGB driver PWM inputs.
//
// PARAMETERS
//   CHANNELS  3   number of PWM outputs (1..16)
//   WIDTH     8   duty/counter width; period = 2^WIDTH-1 ticks
//   PRESCALE  12  clock cycles per PWM tick (>=1; 1 = tick every cycle)
//   CW (local)    $clog2(CHANNELS), minimum 1; width of io_wr_chan
//
// PORTS
//   clock          in   1         system clock
//   reset          in   1         asynchronous, active-low reset
//   io_wr_valid    in   1         duty write request
//   io_wr_ready    out  1         write accepted when valid & ready
//   io_wr_chan     in   CW        target channel
//   io_wr_duty     in   WIDTH     new duty, in ticks high per period
//   io_enable      in   CHANNELS  per-channel output enable
//   io_pwm         out  CHANNELS  registered PWM outputs
//   io_period_end  out  1         1-cycle pulse on each period-boundary load
//
// BEHAVIOUR
//   - Reset (reset=0, async):
//     - prescaler, cnt, shadow[], active[] = 0
//     - io_pwm = 0, io_period_end = 0, io_wr_ready = 0
//   - First clock edge after release: io_wr_ready = 1.
//   - Prescaler: counts 0..PRESCALE-1; tick when it equals PRESCALE-1, then wraps to 0.
//   - cnt: increments on tick over 0..2^WIDTH-2, wraps to 0; never reaches all-ones.
//   - Period end (pend): tick & cnt == 2^WIDTH-2. On that edge:
//     - active[i] loads from shadow[i];
//     - io_period_end pulses high the following cycle.
//   - io_pwm[i] <= io_enable[i] & (cnt < active[i]); one cycle of latency from cnt.
//     - duty 0: constantly low.
//     - duty 2^WIDTH-1: constantly high, no dropout at wrap.
//   - Write handshake:
//     - io_wr_ready is combinationally low in the pend cycle; high otherwise (outside reset).
//     - On valid & ready, shadow[io_wr_chan] <= io_wr_duty.
//     - A master seeing ready low holds valid, chan and duty stable.
//     - Writes never race the load; a write takes effect at the next period end.
//   - io_wr_chan >= CHANNELS: write is accepted (handshake completes) and discarded.
//   - io_enable[i] low: io_pwm[i] is low next cycle; counters and registers keep running.
//   - Reset asserted mid-period: all state clears immediately; the first period after release starts at cnt=0.
//
// CONFIGURATION
//   FADE_EN defined: at each period end, active[i] moves by 1 toward shadow[i]:
//     - +1 if below, -1 if above, hold if equal;
//     - so a change of N takes N periods.
//   FADE_EN undefined: active[i] = shadow[i] directly at period end (single-step jump).
//
// TESTING
//   1. Assert reset mid-run -> io_pwm=0, io_wr_ready=0, io_period_end=0 at once; ready=1 one edge after release.
//   2. WIDTH=4, PRESCALE=1, write ch0=5 -> from the period after next pend: io_pwm[0] high 5 of every 15 cycles.
//   3. Duty checks -> duty 0 gives io_pwm low for 3 periods; duty 15 gives io_pwm high continuously, incl. across the wrap.
//   4. Hold valid into a pend cycle -> ready=0 that cycle; accepted the next cycle; applied at the following pend, not the current one.
//   5. CHANNELS=3, write chan=3 duty=9 -> handshake completes; all shadow/active values unchanged.
//   6. FADE_EN, WIDTH=4: ch1 0->3 -> active 1,2,3 over 3 successive periods; then 3->1 -> active 2,1.

Source files
------------

// File: rtl/pwm_led_driver.sv
// pwm_led_driver: multi-channel PWM generator for LED and pad outputs.
// Per-channel duty is written over a valid/ready port into shadow
// registers. Shadow values move into the active registers only at period
// boundaries, so an output never sees a partial or glitched period.
// Optional feature macro: FADE_EN. When it is defined, each active duty
// moves one step toward its shadow value per period instead of jumping.
module pwm_led_driver #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 12,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_wr_valid,
    output logic                io_wr_ready,
    input  logic [CW-1:0]       io_wr_chan,
    input  logic [WIDTH-1:0]    io_wr_duty,
    input  logic [CHANNELS-1:0] io_enable,
    output logic [CHANNELS-1:0] io_pwm,
    output logic                io_period_end
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    // The counter stops one short of all-ones, so a full-scale duty
    // (all-ones) compares above every count and never drops out.
    localparam logic [WIDTH-1:0] CNT_LAST = ~(WIDTH'(1));

    logic [PW-1:0]    prescaler;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow [CHANNELS];
    logic [WIDTH-1:0] active [CHANNELS];
    logic             ready_q;
    logic             tick;
    logic             pend;
    logic             wr_fire;

    assign tick        = (prescaler == PRE_LAST);
    assign pend        = tick && (cnt == CNT_LAST);
    // Holding off writes during the load cycle keeps a write from racing
    // the shadow-to-active transfer.
    assign io_wr_ready = ready_q & ~pend;
    assign wr_fire     = io_wr_valid & io_wr_ready;

    // Prescaler and period counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            cnt       <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + WIDTH'(1);
            end
        end
    end

    // Write port becomes ready on the first edge after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Shadow registers; an out-of-range channel matches no entry and is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_fire && (io_wr_chan == CW'(i))) begin
                    shadow[i] <= io_wr_duty;
                end
            end
        end
    end

    // Active duty update at each period boundary.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                active[i] <= '0;
            end
        end else if (pend) begin
            for (int i = 0; i < CHANNELS; i++) begin
`ifdef FADE_EN
                if (active[i] < shadow[i]) begin
                    active[i] <= active[i] + WIDTH'(1);
                end else if (active[i] > shadow[i]) begin
                    active[i] <= active[i] - WIDTH'(1);
                end
`else
                active[i] <= shadow[i];
`endif
            end
        end
    end

    // Registered PWM compare and period-end pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_pwm        <= '0;
            io_period_end <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                io_pwm[i] <= io_enable[i] & (cnt < active[i]);
            end
            io_period_end <= pend;
        end
    end

endmodule

// File: tb/tb_pwm_led_driver.sv
// Testbench for pwm_led_driver with CHANNELS=3, WIDTH=4, PRESCALE=1
// (15-cycle period). Expected {period_end, pwm} words are queued per
// scenario and popped one per cycle as the DUT produces them.
module tb_pwm_led_driver;

    localparam int CH  = 3;
    localparam int W   = 4;
    localparam int PER = 15;

    logic         clock = 1'b0;
    logic         reset;
    logic         wr_valid;
    logic         wr_ready;
    logic [1:0]   wr_chan;
    logic [W-1:0] wr_duty;
    logic [CH-1:0] enable;
    logic [CH-1:0] pwm;
    logic          period_end;

    int total = 0;
    int bad   = 0;
    logic [3:0] sbq [$];
    int exp_duty [CH];

    always #5 clock = ~clock;

    pwm_led_driver #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(1)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_wr_valid  (wr_valid),
        .io_wr_ready  (wr_ready),
        .io_wr_chan   (wr_chan),
        .io_wr_duty   (wr_duty),
        .io_enable    (enable),
        .io_pwm       (pwm),
        .io_period_end(period_end)
    );

    // Returns at the negedge where io_period_end is seen high.
    task automatic wait_pe();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 4 * PER && !seen; k++) begin
            @(negedge clock);
            if (period_end === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL wait_period_end: got no pulse want pulse within %0d cycles", 4 * PER);
        end
    endtask

    // Queue n periods of expected output, starting the sample after a period end.
    task automatic push_periods(input int n);
        for (int j = 0; j < n * PER; j++) begin
            logic [3:0] e;
            int c;
            c = j % PER;
            e = '0;
            for (int i = 0; i < CH; i++) e[i] = enable[i] && (c < exp_duty[i]);
            e[3] = (c == PER - 1);
            sbq.push_back(e);
        end
    endtask

    task automatic do_write(input logic [1:0] ch, input logic [W-1:0] d, output logic ok);
        ok       = 1'b0;
        wr_valid = 1'b1;
        wr_chan  = ch;
        wr_duty  = d;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clock);
            if (wr_ready === 1'b1) ok = 1'b1;
        end
        if (ok) @(posedge clock);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        wr_valid = 1'b0;
        wr_chan  = '0;
        wr_duty  = '0;
        enable   = 3'b111;
        for (int i = 0; i < CH; i++) exp_duty[i] = 0;
        #12;
        total++;
        if (pwm !== 3'b000) begin bad++; $display("FAIL reset_pwm: got %b want 000", pwm); end
        total++;
        if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", wr_ready); end
        total++;
        if (period_end !== 1'b0) begin bad++; $display("FAIL reset_pend: got %b want 0", period_end); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        total++;
        if (wr_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge: got %b want 0", wr_ready); end
        @(posedge clock);
        #1;
        total++;
        if (wr_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release: got %b want 1", wr_ready); end
    endtask

    task automatic test_duty();
        logic ok;
        do_write(2'd0, 4'd5, ok);
        do_write(2'd1, 4'd15, ok);
        do_write(2'd2, 4'd0, ok);
        exp_duty[0] = 5;
        exp_duty[1] = 15;
        exp_duty[2] = 0;
        wait_pe();
        push_periods(3);
        while (sbq.size() > 0) begin
            logic [3:0] e;
            @(negedge clock);
            e = sbq.pop_front();
            total++;
            if ({period_end, pwm} !== e) begin
                bad++;
                $display("FAIL duty_pattern: got %b want %b", {period_end, pwm}, e);
            end
        end
    endtask

    task automatic test_enable();
        wait_pe();
        enable = 3'b101;
        push_periods(1);
        while (sbq.size() > 0) begin
            logic [3:0] e;
            @(negedge clock);
            e = sbq.pop_front();
            total++;
            if ({period_end, pwm} !== e) begin
                bad++;
                $display("FAIL enable_mask: got %b want %b", {period_end, pwm}, e);
            end
        end
        enable = 3'b111;
    endtask

    task automatic test_pend_hold();
        wait_pe();
        repeat (14) @(negedge clock);
        wr_valid = 1'b1;
        wr_chan  = 2'd0;
        wr_duty  = 4'd7;
        total++;
        if (wr_ready !== 1'b0) begin bad++; $display("FAIL ready_in_pend: got %b want 0", wr_ready); end
        @(negedge clock);
        total++;
        if (wr_ready !== 1'b1) begin bad++; $display("FAIL ready_after_pend: got %b want 1", wr_ready); end
        total++;
        if (period_end !== 1'b1) begin bad++; $display("FAIL pend_pulse: got %b want 1", period_end); end
        @(posedge clock);
        #1;
        wr_valid = 1'b0;
        push_periods(1);
        exp_duty[0] = 7;
        push_periods(1);
        while (sbq.size() > 0) begin
            logic [3:0] e;
            @(negedge clock);
            e = sbq.pop_front();
            total++;
            if ({period_end, pwm} !== e) begin
                bad++;
                $display("FAIL held_write_apply: got %b want %b", {period_end, pwm}, e);
            end
        end
    endtask

    task automatic test_fade();
        logic ok;
        do_write(2'd1, 4'd3, ok);
        wait_pe();
        for (int s = 1; s <= 3; s++) begin
            exp_duty[1] = s;
            push_periods(1);
        end
        while (sbq.size() > 0) begin
            logic [3:0] e;
            @(negedge clock);
            e = sbq.pop_front();
            total++;
            if ({period_end, pwm} !== e) begin
                bad++;
                $display("FAIL fade_up: got %b want %b", {period_end, pwm}, e);
            end
        end
        do_write(2'd1, 4'd1, ok);
        wait_pe();
        exp_duty[1] = 2;
        push_periods(1);
        exp_duty[1] = 1;
        push_periods(1);
        while (sbq.size() > 0) begin
            logic [3:0] e;
            @(negedge clock);
            e = sbq.pop_front();
            total++;
            if ({period_end, pwm} !== e) begin
                bad++;
                $display("FAIL fade_down: got %b want %b", {period_end, pwm}, e);
            end
        end
    endtask

    task automatic test_bad_chan();
        logic ok;
        do_write(2'd3, 4'd9, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL bad_chan_handshake: got %b want 1", ok); end
        wait_pe();
        push_periods(2);
        while (sbq.size() > 0) begin
            logic [3:0] e;
            @(negedge clock);
            e = sbq.pop_front();
            total++;
            if ({period_end, pwm} !== e) begin
                bad++;
                $display("FAIL bad_chan_unchanged: got %b want %b", {period_end, pwm}, e);
            end
        end
    endtask

    task automatic test_midrun_reset();
        int k;
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        total++;
        if (pwm !== 3'b000) begin bad++; $display("FAIL midrun_pwm: got %b want 000", pwm); end
        total++;
        if (wr_ready !== 1'b0) begin bad++; $display("FAIL midrun_ready: got %b want 0", wr_ready); end
        total++;
        if (period_end !== 1'b0) begin bad++; $display("FAIL midrun_pend: got %b want 0", period_end); end
        for (int i = 0; i < CH; i++) exp_duty[i] = 0;
        @(negedge clock);
        reset = 1'b1;
        push_periods(1);
        k = 0;
        while (sbq.size() > 0) begin
            logic [3:0] e;
            @(negedge clock);
            e = sbq.pop_front();
            if (k == 0) begin
                total++;
                if (wr_ready !== 1'b1) begin bad++; $display("FAIL midrun_ready_back: got %b want 1", wr_ready); end
            end
            total++;
            if ({period_end, pwm} !== e) begin
                bad++;
                $display("FAIL first_period_after_reset: got %b want %b", {period_end, pwm}, e);
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
`ifdef FADE_EN
        test_fade();
`else
        test_duty();
        test_enable();
        test_pend_hold();
`endif
        test_bad_chan();
        test_midrun_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
